// File: rtl/msg_pkg.sv
// msg_pkg
// Shared definitions for the market-feed arbiter slice: beat field widths,
// arbiter FSM state encodings and a helper for channel-index widths.
// No ports (package).
package msg_pkg;

  localparam int MSG_DATA_W  = 64;
  localparam int MSG_EMPTY_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_t;

  // Width of a channel index; never below one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/msg_feed_arbiter_if.sv
// msg_feed_arbiter_if
// Bundles the NUM_CH Avalon-ST input channels, the merged output stream and
// the abort statistic pulse of the feed arbiter.
// Modports:
//   slave  - arbiter side: sinks the channel inputs, sources the merged stream
//   master - environment side: sources the channels, sinks the merged stream
// Parameter: NUM_CH - number of input channels.
interface msg_feed_arbiter_if
  import msg_pkg::*;
#(
  parameter int NUM_CH = 4
);

  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0]             in_valid;
  logic [NUM_CH-1:0]             in_ready;
  logic [MSG_DATA_W*NUM_CH-1:0]  in_data;
  logic [NUM_CH-1:0]             in_startofpacket;
  logic [NUM_CH-1:0]             in_endofpacket;
  logic [NUM_CH-1:0]             in_error;
  logic [MSG_EMPTY_W*NUM_CH-1:0] in_empty;

  logic                          out_valid;
  logic                          out_ready;
  logic [MSG_DATA_W-1:0]         out_data;
  logic                          out_startofpacket;
  logic                          out_endofpacket;
  logic                          out_error;
  logic [MSG_EMPTY_W-1:0]        out_empty;
  logic [CH_W-1:0]               out_channel;
  logic                          stat_abort;

  modport slave (
    input  in_valid, in_data, in_startofpacket, in_endofpacket, in_error, in_empty,
    output in_ready,
    output out_valid, out_data, out_startofpacket, out_endofpacket, out_error,
    output out_empty, out_channel, stat_abort,
    input  out_ready
  );

  modport master (
    output in_valid, in_data, in_startofpacket, in_endofpacket, in_error, in_empty,
    input  in_ready,
    input  out_valid, out_data, out_startofpacket, out_endofpacket, out_error,
    input  out_empty, out_channel, stat_abort,
    output out_ready
  );

endinterface

// File: rtl/msg_feed_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin picker: returns the first requesting channel
// strictly after last_grant, wrapping modulo NUM_CH.
// Ports:
//   req        in   NUM_CH  request vector
//   last_grant in   CH_W    channel that finished most recently
//   any_req    out  1       at least one request present
//   pick       out  CH_W    winning channel (0 when no request)
module rr_arbiter
  import msg_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int CH_W = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic              any_req,
  output logic [CH_W-1:0]   pick
);

  logic [CH_W-1:0] idx;

  // Scan from last_grant+1 around to last_grant itself, so the previous
  // owner is considered last and can never win twice over a waiting peer.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(last_grant) + k) % NUM_CH);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

endmodule

// File: rtl/msg_feed_arbiter.sv
// msg_feed_arbiter
// Packet-granular round-robin merge of NUM_CH Avalon-ST 64-bit feed channels
// onto one stream for the message extractor. A grant is held from SOP to EOP,
// orphan beats are drained while idle, and a packet whose source stalls for
// STALL_MAX cycles is closed with an error EOP beat.
// Ports:
//   clk   in  1  clock, all logic on posedge
//   reset in  1  synchronous active-high reset
//   bus   msg_feed_arbiter_if.slave  channel inputs, merged output, stat_abort
// Parameters: NUM_CH (2..16), STALL_MAX (0 disables watchdog), STALL_W.
module msg_feed_arbiter
  import msg_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int STALL_MAX = 255,
  parameter int STALL_W   = 8,
  localparam int CH_W     = ch_width(NUM_CH)
) (
  input logic               clk,
  input logic               reset,
  msg_feed_arbiter_if.slave bus
);

  arb_state_t         state, state_nxt;
  logic [CH_W-1:0]    grant, grant_nxt;
  logic [CH_W-1:0]    last_grant, last_grant_nxt;
  logic [STALL_W-1:0] stall_cnt, stall_nxt;

  logic [NUM_CH-1:0]      req;
  logic                   any_req;
  logic [CH_W-1:0]        pick;
  logic [MSG_DATA_W-1:0]  ch_data  [NUM_CH];
  logic [MSG_EMPTY_W-1:0] ch_empty [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i]  = bus.in_data[i*MSG_DATA_W +: MSG_DATA_W];
    assign ch_empty[i] = bus.in_empty[i*MSG_EMPTY_W +: MSG_EMPTY_W];
  end

  assign req = bus.in_valid & bus.in_startofpacket;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .pick       (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      stall_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      stall_cnt  <= stall_nxt;
    end
  end

  // Outputs are forced quiet while reset is high, since the state register
  // only clears on the following edge.
  always_comb begin
    state_nxt             = state;
    grant_nxt             = grant;
    last_grant_nxt        = last_grant;
    stall_nxt             = stall_cnt;
    bus.in_ready          = '0;
    bus.out_valid         = 1'b0;
    bus.out_data          = '0;
    bus.out_startofpacket = 1'b0;
    bus.out_endofpacket   = 1'b0;
    bus.out_error         = 1'b0;
    bus.out_empty         = '0;
    bus.out_channel       = grant;
    bus.stat_abort        = 1'b0;

    if (!reset) begin
      unique case (state)
        ST_IDLE: begin
          // Non-SOP beats are swallowed; SOP beats wait for a grant.
          bus.in_ready = bus.in_valid & ~bus.in_startofpacket;
          stall_nxt    = '0;
          if (any_req) begin
            grant_nxt = pick;
            state_nxt = ST_XFER;
          end
        end

        ST_XFER: begin
          bus.out_valid         = bus.in_valid[grant];
          bus.out_data          = ch_data[grant];
          bus.out_startofpacket = bus.in_startofpacket[grant];
          bus.out_endofpacket   = bus.in_endofpacket[grant];
          bus.out_error         = bus.in_error[grant];
          bus.out_empty         = ch_empty[grant];
          bus.in_ready[grant]   = bus.out_ready;
          // Only an idle source counts toward the watchdog; downstream
          // backpressure never does.
          if (bus.in_valid[grant]) begin
            stall_nxt = '0;
            if (bus.out_ready && bus.in_endofpacket[grant]) begin
              last_grant_nxt = grant;
              state_nxt      = ST_IDLE;
            end
          end else begin
            stall_nxt = stall_cnt + STALL_W'(1);
            if (STALL_MAX != 0 && stall_cnt == STALL_W'(STALL_MAX - 1)) begin
              state_nxt = ST_ABORT;
            end
          end
        end

        ST_ABORT: begin
          // Synthetic terminating beat; the source's leftovers are drained
          // later as orphans.
          bus.out_valid       = 1'b1;
          bus.out_endofpacket = 1'b1;
          bus.out_error       = 1'b1;
          if (bus.out_ready) begin
            bus.stat_abort = 1'b1;
            last_grant_nxt = grant;
            stall_nxt      = '0;
            state_nxt      = ST_IDLE;
          end
        end

        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_feed_arbiter.sv
// tb_msg_feed_arbiter
// Directed self-checking bench for msg_feed_arbiter with NUM_CH=4 and
// STALL_MAX=4. Inputs change 1 time unit after each rising edge; outputs are
// compared 2 units later, well clear of either edge.
module tb_msg_feed_arbiter;

  localparam int NUM_CH = 4;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic saw_abort;

  msg_feed_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

  msg_feed_arbiter #(
    .NUM_CH    (NUM_CH),
    .STALL_MAX (4),
    .STALL_W   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ch, input logic v, input logic sop, input logic eop,
                       input logic [63:0] d, input logic [2:0] e, input logic err);
    bus.in_valid[ch]          = v;
    bus.in_startofpacket[ch]  = sop;
    bus.in_endofpacket[ch]    = eop;
    bus.in_error[ch]          = err;
    bus.in_data[ch*64 +: 64]  = d;
    bus.in_empty[ch*3 +: 3]   = e;
  endtask

  task automatic clear_all();
    bus.in_valid         = '0;
    bus.in_startofpacket = '0;
    bus.in_endofpacket   = '0;
    bus.in_error         = '0;
    bus.in_data          = '0;
    bus.in_empty         = '0;
  endtask

  function automatic logic [63:0] pat(input int ch, input int beat);
    return 64'hC0DE_0000_0000_0000 | (64'(ch) << 8) | 64'(beat);
  endfunction

  initial begin
    vectors       = 0;
    miscompares   = 0;
    saw_abort     = 1'b0;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    clear_all();

    // Reset: an orphan beat is offered, but nothing may be ready or valid.
    drive(0, 1, 0, 0, pat(0, 7), 3'd0, 0);
    tick();
    tick();
    #2;
    check("rst in_ready", 64'(bus.in_ready), 0);
    check("rst out_valid", 64'(bus.out_valid), 0);
    check("rst stat_abort", 64'(bus.stat_abort), 0);
    reset = 1'b0;
    clear_all();

    // 1: three-beat packet on ch0 with an IDLE bubble first.
    drive(0, 1, 1, 0, pat(0, 0), 3'd0, 0);
    #2;
    check("t1 bubble out_valid", 64'(bus.out_valid), 0);
    check("t1 bubble in_ready", 64'(bus.in_ready), 0);
    tick();
    #2;
    check("t1 b0 out_valid", 64'(bus.out_valid), 1);
    check("t1 b0 channel", 64'(bus.out_channel), 0);
    check("t1 b0 data", bus.out_data, pat(0, 0));
    check("t1 b0 sop", 64'(bus.out_startofpacket), 1);
    check("t1 b0 in_ready", 64'(bus.in_ready), 1);
    tick();
    drive(0, 1, 0, 0, pat(0, 1), 3'd0, 1);
    #2;
    check("t1 b1 data", bus.out_data, pat(0, 1));
    check("t1 b1 sop", 64'(bus.out_startofpacket), 0);
    check("t1 b1 error", 64'(bus.out_error), 1);
    tick();
    drive(0, 1, 0, 1, pat(0, 2), 3'd5, 0);
    #2;
    check("t1 b2 data", bus.out_data, pat(0, 2));
    check("t1 b2 eop", 64'(bus.out_endofpacket), 1);
    check("t1 b2 empty", 64'(bus.out_empty), 5);
    tick();
    clear_all();
    #2;
    check("t1 done out_valid", 64'(bus.out_valid), 0);

    // 2: all four channels request at once after a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++) drive(ch, 1, 1, 0, pat(ch, 0), 3'd0, 0);
    for (int k = 0; k < NUM_CH; k++) begin
      #2;
      check("t2 idle out_valid", 64'(bus.out_valid), 0);
      check("t2 idle in_ready", 64'(bus.in_ready), 0);
      tick();
      #2;
      check("t2 grant channel", 64'(bus.out_channel), 64'(k));
      check("t2 b0 data", bus.out_data, pat(k, 0));
      check("t2 b0 in_ready", 64'(bus.in_ready), 64'(1) << k);
      tick();
      drive(k, 1, 0, 1, pat(k, 1), 3'd0, 0);
      #2;
      check("t2 b1 data", bus.out_data, pat(k, 1));
      check("t2 b1 eop", 64'(bus.out_endofpacket), 1);
      tick();
      drive(k, 0, 0, 0, 64'd0, 3'd0, 0);
    end
    drive(0, 1, 1, 0, pat(0, 0), 3'd0, 0);
    drive(1, 1, 1, 0, pat(1, 0), 3'd0, 0);
    tick();
    #2;
    check("t2 next round channel", 64'(bus.out_channel), 0);
    tick();
    drive(1, 0, 0, 0, 64'd0, 3'd0, 0);
    drive(0, 1, 0, 1, pat(0, 1), 3'd0, 0);
    tick();
    clear_all();

    // 3: long backpressure mid-packet on ch2 must not trip the watchdog.
    drive(2, 1, 1, 0, pat(2, 0), 3'd0, 0);
    tick();
    #2;
    check("t3 grant channel", 64'(bus.out_channel), 2);
    tick();
    drive(2, 1, 0, 0, pat(2, 1), 3'd0, 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 400; i++) begin
      #2;
      if (bus.stat_abort || bus.out_error || !bus.out_valid) saw_abort = 1'b1;
      tick();
    end
    #2;
    check("t3 no abort", 64'(saw_abort), 0);
    check("t3 held data", bus.out_data, pat(2, 1));
    check("t3 held in_ready", 64'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    tick();
    drive(2, 1, 0, 1, pat(2, 2), 3'd2, 0);
    #2;
    check("t3 b2 data", bus.out_data, pat(2, 2));
    check("t3 b2 eop", 64'(bus.out_endofpacket), 1);
    check("t3 b2 empty", 64'(bus.out_empty), 2);
    tick();
    clear_all();

    // 4: ch1 stalls after its first beat; abort, then ch3 wins while ch1 drains.
    drive(1, 1, 1, 0, pat(1, 0), 3'd0, 0);
    tick();
    #2;
    check("t4 grant channel", 64'(bus.out_channel), 1);
    tick();
    drive(1, 0, 0, 0, 64'd0, 3'd0, 0);
    drive(3, 1, 1, 1, pat(3, 0), 3'd0, 0);
    tick();
    tick();
    tick();
    #2;
    check("t4 stall out_valid", 64'(bus.out_valid), 0);
    check("t4 stall stat_abort", 64'(bus.stat_abort), 0);
    tick();
    #2;
    check("t4 abort out_valid", 64'(bus.out_valid), 1);
    check("t4 abort eop", 64'(bus.out_endofpacket), 1);
    check("t4 abort error", 64'(bus.out_error), 1);
    check("t4 abort sop", 64'(bus.out_startofpacket), 0);
    check("t4 abort data", bus.out_data, 0);
    check("t4 abort empty", 64'(bus.out_empty), 0);
    check("t4 abort channel", 64'(bus.out_channel), 1);
    check("t4 abort in_ready", 64'(bus.in_ready), 0);
    check("t4 stat_abort", 64'(bus.stat_abort), 1);
    tick();
    drive(1, 1, 0, 0, pat(1, 1), 3'd0, 0);
    #2;
    check("t4 drain in_ready", 64'(bus.in_ready), 2);
    check("t4 idle out_valid", 64'(bus.out_valid), 0);
    check("t4 pulse width", 64'(bus.stat_abort), 0);
    tick();
    drive(1, 1, 0, 1, pat(1, 2), 3'd0, 0);
    #2;
    check("t4 ch3 channel", 64'(bus.out_channel), 3);
    check("t4 ch3 in_ready", 64'(bus.in_ready), 8);
    check("t4 ch3 data", bus.out_data, pat(3, 0));
    tick();
    drive(3, 0, 0, 0, 64'd0, 3'd0, 0);
    #2;
    check("t4 drain eop in_ready", 64'(bus.in_ready), 2);
    tick();
    clear_all();

    // 5: orphan beats on ch3 in IDLE are drained, then its SOP is granted.
    drive(3, 1, 0, 0, pat(3, 1), 3'd0, 0);
    #2;
    check("t5 orphan1 in_ready", 64'(bus.in_ready), 8);
    check("t5 orphan1 out_valid", 64'(bus.out_valid), 0);
    tick();
    drive(3, 1, 0, 1, pat(3, 2), 3'd0, 0);
    #2;
    check("t5 orphan2 in_ready", 64'(bus.in_ready), 8);
    check("t5 orphan2 out_valid", 64'(bus.out_valid), 0);
    tick();
    drive(3, 1, 1, 1, pat(3, 0), 3'd7, 0);
    #2;
    check("t5 sop wait in_ready", 64'(bus.in_ready), 0);
    tick();
    #2;
    check("t5 grant channel", 64'(bus.out_channel), 3);
    check("t5 data", bus.out_data, pat(3, 0));
    check("t5 sop", 64'(bus.out_startofpacket), 1);
    check("t5 eop", 64'(bus.out_endofpacket), 1);
    check("t5 empty", 64'(bus.out_empty), 7);
    tick();
    clear_all();
    #2;
    check("t5 single beat done", 64'(bus.out_valid), 0);

    // 6: ch0 wins once (last_grant=0), then reset mid-packet restores ch0 priority.
    tick();
    drive(0, 1, 1, 1, pat(0, 0), 3'd0, 0);
    tick();
    #2;
    check("t6 single channel", 64'(bus.out_channel), 0);
    tick();
    drive(0, 1, 1, 0, pat(0, 0), 3'd0, 0);
    tick();
    tick();
    drive(0, 1, 0, 0, pat(0, 1), 3'd0, 0);
    tick();
    drive(0, 1, 0, 0, pat(0, 2), 3'd0, 0);
    #2;
    check("t6 beat2 data", bus.out_data, pat(0, 2));
    reset = 1'b1;
    #2;
    check("t6 rst out_valid", 64'(bus.out_valid), 0);
    check("t6 rst in_ready", 64'(bus.in_ready), 0);
    tick();
    #2;
    check("t6 rst next out_valid", 64'(bus.out_valid), 0);
    check("t6 rst next in_ready", 64'(bus.in_ready), 0);
    reset = 1'b0;
    drive(0, 1, 1, 0, pat(0, 9), 3'd0, 0);
    drive(1, 1, 1, 0, pat(1, 0), 3'd0, 0);
    #2;
    check("t6 post-reset idle", 64'(bus.out_valid), 0);
    tick();
    #2;
    check("t6 post-reset channel", 64'(bus.out_channel), 0);
    check("t6 post-reset data", bus.out_data, pat(0, 9));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
